// File: rtl/program_sequencer.sv
// Multi-cycle instruction sequencer: owns the PC, steps FETCH..WB, gates decoder
// write enables by phase, resolves jumps/branches and keeps performance counters.
module program_sequencer #(
    parameter int unsigned PC_W        = 12,
    parameter int unsigned PROG_LEN    = 1024,
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    output logic              done,
    output logic [PC_W-1:0]   prog_ctr,
    output logic              decode_en,
    input  logic              branch_flag,
    input  logic              cond_branch,
    input  logic              alu_cond,
    input  logic [PC_W-1:0]   target,
    input  logic              mem_to_reg_in,
    input  logic              mem_write_in,
    input  logic              reg_write_in,
    input  logic              mem_ready,
    output logic              mem_write_en,
    output logic              reg_write_en,
    output logic [2:0]        state,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  instr_cnt
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t             r_state;
    logic [PC_W-1:0]    r_pc;
    logic               r_done;
    logic               r_decode_en;
    logic               r_taken;
    logic               r_no_rf;
    logic [WAIT_W-1:0]  r_wait;
    logic [CNT_W-1:0]   r_cycle;
    logic [CNT_W-1:0]   r_instr;
    logic               w_busy;
    logic               w_mem_exit;

    assign w_busy     = (r_state == S_FETCH) || (r_state == S_DECODE) || (r_state == S_EXEC)
                     || (r_state == S_MEM)   || (r_state == S_WB);
    assign w_mem_exit = mem_ready || (r_wait == WAIT_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_pc        <= '0;
            r_done      <= 1'b0;
            r_decode_en <= 1'b0;
            r_taken     <= 1'b0;
            r_no_rf     <= 1'b0;
            r_wait      <= '0;
            r_cycle     <= '0;
            r_instr     <= '0;
        end else begin
            r_decode_en <= 1'b0;
            if (w_busy && (r_cycle != '1)) begin
                r_cycle <= r_cycle + CNT_W'(1);
            end
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_pc    <= '0;
                        r_cycle <= '0;
                        r_instr <= '0;
                        r_done  <= 1'b0;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (32'(r_pc) >= PROG_LEN) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_decode_en <= 1'b1;
                        r_state     <= S_DECODE;
                    end
                end
                S_DECODE: r_state <= S_EXEC;
                S_EXEC: begin
                    // Branch decision and RF-write suppression are latched for WB.
                    r_taken <= branch_flag | (cond_branch & alu_cond);
                    r_no_rf <= branch_flag | cond_branch | mem_write_in;
                    r_wait  <= '0;
                    r_state <= (mem_to_reg_in || mem_write_in) ? S_MEM : S_WB;
                end
                S_MEM: begin
                    r_wait <= r_wait + WAIT_W'(1);
                    if (w_mem_exit) begin
                        r_state <= S_WB;
                    end
                end
                S_WB: begin
                    r_pc    <= r_taken ? target : r_pc + PC_W'(1);
                    if (r_instr != '1) begin
                        r_instr <= r_instr + CNT_W'(1);
                    end
                    r_state <= S_FETCH;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Write enables are phase-decoded; the store strobe only fires on the first MEM cycle.
    assign mem_write_en = (r_state == S_MEM) && (r_wait == '0) && mem_write_in;
    assign reg_write_en = (r_state == S_WB) && reg_write_in && !r_no_rf;

    assign done      = r_done;
    assign prog_ctr  = r_pc;
    assign decode_en = r_decode_en;
    assign state     = r_state;
    assign cycle_cnt = r_cycle;
    assign instr_cnt = r_instr;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed self-checking bench for program_sequencer; a small ROM keyed on prog_ctr
// plays the decoder, a second instance with PROG_LEN=3 covers the DONE path.
module tb_program_sequencer;

    logic        Clk;
    logic        Reset;
    logic        start;
    logic        done;
    logic [11:0] prog_ctr;
    logic        decode_en;
    logic        branch_flag;
    logic        cond_branch;
    logic        alu_cond;
    logic [11:0] target;
    logic        mem_to_reg_in;
    logic        mem_write_in;
    logic        reg_write_in;
    logic        mem_ready;
    logic        mem_write_en;
    logic        reg_write_en;
    logic [2:0]  state;
    logic [15:0] cycle_cnt;
    logic [15:0] instr_cnt;

    logic        s_start;
    logic        s_done;
    logic [11:0] s_pc;
    logic        s_dec;
    logic        s_mwe;
    logic        s_rwe;
    logic [2:0]  s_state;
    logic [15:0] s_cyc;
    logic [15:0] s_instr;

    logic        cond_val;
    int          n_checks;
    int          n_errors;

    program_sequencer dut (
        .Clk(Clk), .Reset(Reset), .start(start), .done(done), .prog_ctr(prog_ctr),
        .decode_en(decode_en), .branch_flag(branch_flag), .cond_branch(cond_branch),
        .alu_cond(alu_cond), .target(target), .mem_to_reg_in(mem_to_reg_in),
        .mem_write_in(mem_write_in), .reg_write_in(reg_write_in), .mem_ready(mem_ready),
        .mem_write_en(mem_write_en), .reg_write_en(reg_write_en), .state(state),
        .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
    );

    program_sequencer #(.PROG_LEN(3)) dut_short (
        .Clk(Clk), .Reset(Reset), .start(s_start), .done(s_done), .prog_ctr(s_pc),
        .decode_en(s_dec), .branch_flag(1'b0), .cond_branch(1'b0),
        .alu_cond(1'b0), .target(12'h000), .mem_to_reg_in(1'b0),
        .mem_write_in(1'b0), .reg_write_in(1'b1), .mem_ready(1'b1),
        .mem_write_en(s_mwe), .reg_write_en(s_rwe), .state(s_state),
        .cycle_cnt(s_cyc), .instr_cnt(s_instr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Program image seen by the main instance.
    always_comb begin
        branch_flag   = 1'b0;
        cond_branch   = 1'b0;
        alu_cond      = 1'b0;
        target        = 12'h000;
        mem_to_reg_in = 1'b0;
        mem_write_in  = 1'b0;
        reg_write_in  = 1'b0;
        case (prog_ctr)
            12'h000, 12'h001, 12'h002, 12'h003, 12'h004: reg_write_in = 1'b1;
            12'h005: begin branch_flag = 1'b1; target = 12'h020; reg_write_in = 1'b1; end
            12'h020: begin branch_flag = 1'b1; target = 12'h007; end
            12'h007: begin cond_branch = 1'b1; alu_cond = cond_val; target = 12'h100; end
            12'h008: begin branch_flag = 1'b1; target = 12'h007; end
            12'h100: begin mem_write_in = 1'b1; reg_write_in = 1'b1; end
            12'h101, 12'h102: mem_write_in = 1'b1;
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic wait_fetch(input logic [11:0] pc, input int budget);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge Clk);
            if (state == 3'd1 && prog_ctr == pc) hit = 1'b1;
        end
        chk("reach_fetch_pc", 32'(hit), 32'd1);
    endtask

    initial begin
        int          n;
        logic [15:0] c0;
        logic [31:0] mask;
        int          done_cyc;
        int          dec_cnt;
        logic [2:0]  st13;
        logic [11:0] pc13;

        n_checks  = 0;
        n_errors  = 0;
        Reset     = 1'b1;
        start     = 1'b0;
        s_start   = 1'b0;
        mem_ready = 1'b0;
        cond_val  = 1'b0;
        step(2);
        chk("rst_state",  32'(state), 32'd0);
        chk("rst_pc",     32'(prog_ctr), 32'd0);
        chk("rst_done",   32'(done), 32'd0);
        chk("rst_dec",    32'(decode_en), 32'd0);
        chk("rst_cycle",  32'(cycle_cnt), 32'd0);
        chk("rst_instr",  32'(instr_cnt), 32'd0);
        Reset = 1'b0;
        step(1);

        // ALU instruction timing and start ignored mid-instruction.
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("fetch0_state", 32'(state), 32'd1);
        chk("fetch0_pc",    32'(prog_ctr), 32'd0);
        step(1);
        chk("decode_en",    32'(decode_en), 32'd1);
        chk("decode_state", 32'(state), 32'd2);
        step(1);
        chk("exec_state",   32'(state), 32'd3);
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("wb_state",     32'(state), 32'd5);
        chk("wb_rwe",       32'(reg_write_en), 32'd1);
        chk("wb_dec_low",   32'(decode_en), 32'd0);
        step(1);
        chk("fetch1_pc",    32'(prog_ctr), 32'd1);
        chk("fetch1_cycle", 32'(cycle_cnt), 32'd4);
        chk("fetch1_instr", 32'(instr_cnt), 32'd1);

        // Jump at PC 5 to 0x020, no register write in its WB.
        wait_fetch(12'h005, 40);
        step(3);
        chk("jmp_wb_state", 32'(state), 32'd5);
        chk("jmp_wb_rwe",   32'(reg_write_en), 32'd0);
        step(1);
        chk("jmp_pc",       32'(prog_ctr), 32'h020);

        // Conditional branch at PC 7: not taken, then taken.
        wait_fetch(12'h007, 20);
        step(4);
        chk("br_nt_state",  32'(state), 32'd1);
        chk("br_nt_pc",     32'(prog_ctr), 32'h008);
        cond_val = 1'b1;
        wait_fetch(12'h007, 20);
        step(4);
        chk("br_t_pc",      32'(prog_ctr), 32'h100);

        // Store with mem_ready low for three MEM cycles.
        c0 = cycle_cnt;
        step(3);
        chk("st_mem1_state", 32'(state), 32'd4);
        chk("st_mem1_mwe",   32'(mem_write_en), 32'd1);
        step(1);
        chk("st_mem2_mwe",   32'(mem_write_en), 32'd0);
        step(2);
        chk("st_mem4_state", 32'(state), 32'd4);
        mem_ready = 1'b1;
        step(1);
        mem_ready = 1'b0;
        chk("st_wb_state",   32'(state), 32'd5);
        chk("st_wb_rwe",     32'(reg_write_en), 32'd0);
        step(1);
        chk("st_next_pc",    32'(prog_ctr), 32'h101);
        chk("st_latency",    32'(cycle_cnt - c0), 32'd8);

        // Store with mem_ready never rising: forced out after the timeout.
        c0 = cycle_cnt;
        step(3);
        n = 0;
        while (state == 3'd4 && n < 40) begin
            n++;
            step(1);
        end
        chk("to_mem_len",    32'(n), 32'd15);
        chk("to_wb_state",   32'(state), 32'd5);
        step(1);
        chk("to_next_pc",    32'(prog_ctr), 32'h102);
        chk("to_latency",    32'(cycle_cnt - c0), 32'd19);

        // Reset during the first MEM cycle of a store.
        step(3);
        chk("rm_mwe_before", 32'(mem_write_en), 32'd1);
        #2 Reset = 1'b1;
        step(1);
        chk("rm_state", 32'(state), 32'd0);
        chk("rm_pc",    32'(prog_ctr), 32'd0);
        chk("rm_mwe",   32'(mem_write_en), 32'd0);
        chk("rm_rwe",   32'(reg_write_en), 32'd0);
        chk("rm_cycle", 32'(cycle_cnt), 32'd0);
        chk("rm_instr", 32'(instr_cnt), 32'd0);
        Reset = 1'b0;
        step(1);

        // Three-instruction program on the PROG_LEN=3 instance.
        s_start = 1'b1;
        step(1);
        s_start = 1'b0;
        mask     = '0;
        done_cyc = 0;
        dec_cnt  = 0;
        st13     = '0;
        pc13     = '0;
        for (int k = 1; k <= 20; k++) begin
            if (s_rwe) mask[k] = 1'b1;
            if (s_dec) dec_cnt++;
            if (k == 13) begin
                st13 = s_state;
                pc13 = s_pc;
            end
            if (s_done && done_cyc == 0) done_cyc = k;
            step(1);
        end
        chk("sh_rwe_cycles", mask, 32'h0000_1110);
        chk("sh_dec_count",  32'(dec_cnt), 32'd3);
        chk("sh_c13_state",  32'(st13), 32'd1);
        chk("sh_c13_pc",     32'(pc13), 32'd3);
        chk("sh_done_cycle", 32'(done_cyc), 32'd14);
        chk("sh_state",      32'(s_state), 32'd6);
        chk("sh_instr",      32'(s_instr), 32'd3);
        chk("sh_cycle",      32'(s_cyc), 32'd13);
        chk("sh_mwe",        32'(s_mwe), 32'd0);

        // Restart from DONE.
        s_start = 1'b1;
        step(1);
        s_start = 1'b0;
        chk("rs_state", 32'(s_state), 32'd1);
        chk("rs_pc",    32'(s_pc), 32'd0);
        chk("rs_cycle", 32'(s_cyc), 32'd0);
        chk("rs_instr", 32'(s_instr), 32'd0);
        chk("rs_done",  32'(s_done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
- Multi-cycle instruction sequencer that owns the program counter and steps the datapath through fetch, decode, execute, memory and writeback phases.
- Gates the write enables produced by the instruction decoder so that register and memory writes happen only in their phase.
- Resolves jumps and conditional branches.
- Runs a start/done handshake with the testbench, and counts cycles and retired instructions for performance reporting.

Parameters:
PC_W, 12, program counter width (matches instruction ROM address).
PROG_LEN, 1024, PC value at which the program is considered finished.
MEM_TIMEOUT, 15, max cycles to wait for mem_ready before forcing completion.
CNT_W, 16, width of cycle and retired-instruction counters.

Ports:
Clk  in  1  system clock, rising edge.
Reset  in  1  asynchronous, active-high reset.
start  in  1  pulse: begin execution from PC 0.
done  out  1  high while in DONE state.
prog_ctr  out  PC_W  current instruction ROM address.
decode_en  out  1  instruction register / decoder capture strobe.
branch_flag  in  1  decoder: unconditional jump.
cond_branch  in  1  decoder: conditional branch opcode (eq/lt/gt/signed lt/gt).
alu_cond  in  1  ALU comparison result, valid in EXEC.
target  in  PC_W  branch/jump destination from target lookup.
mem_to_reg_in  in  1  decoder load flag.
mem_write_in  in  1  decoder store flag.
reg_write_in  in  1  decoder register-write flag.
mem_ready  in  1  data memory access complete.
mem_write_en  out  1  gated store enable.
reg_write_en  out  1  gated register-file write enable.
state  out  3  current state encoding.
cycle_cnt  out  CNT_W  cycles since start.
instr_cnt  out  CNT_W  retired instructions.

Behaviour:
- Reset (async, immediate) values:
  - state=IDLE, prog_ctr=0, done=0, decode_en=0, mem_write_en=0, reg_write_en=0, cycle_cnt=0, instr_cnt=0.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, DONE=6. Code 7 is illegal and goes to IDLE.
- IDLE:
  - Wait for start=1.
  - On start: prog_ctr<=0, cycle_cnt<=0, instr_cnt<=0, go to FETCH.
  - start in any other state is ignored.
- FETCH:
  - One cycle; ROM read uses prog_ctr.
  - If prog_ctr>=PROG_LEN, go to DONE; else go to DECODE.
- DECODE:
  - decode_en=1 for exactly this cycle, then go to EXEC.
- EXEC:
  - One cycle; the decoder inputs are sampled here.
  - Branch resolution: taken = branch_flag | (cond_branch & alu_cond).
  - If mem_to_reg_in or mem_write_in, go to MEM; else go to WB.
  - The taken decision is latched here and applied at WB exit.
- MEM:
  - mem_write_en = mem_write_in, asserted for exactly one cycle (the first MEM cycle).
  - Stay in MEM until mem_ready=1, or until the wait counter reaches MEM_TIMEOUT cycles; either one moves to WB.
  - The wait counter clears on MEM entry.
- WB:
  - reg_write_en = reg_write_in for this one cycle; it is never asserted for stores or branches.
  - On exit: prog_ctr <= taken ? target : prog_ctr+1.
  - On exit: instr_cnt increments (saturating at all-ones), then go to FETCH.
- PC increment wraps modulo 2^PC_W. A wrap to 0 does not itself halt.
- DONE:
  - done=1; hold until start=1, which restarts exactly like the IDLE start path.
- Latency:
  - ALU instruction: 4 cycles, FETCH to the next FETCH.
  - Memory instruction: 5+N cycles, where N is the cycles mem_ready stays low after the first MEM cycle.
- cycle_cnt increments every cycle in states FETCH..WB, saturates at all-ones, and is frozen in IDLE/DONE.
- Simultaneous events:
  - mem_ready high on the first MEM cycle: MEM lasts exactly one cycle.
  - branch_flag and cond_branch both high: taken=1.
  - Reset has priority over all other events. Reset mid-instruction aborts with no write enables asserted in the following cycle.
- All outputs are registered except mem_write_en and reg_write_en, which are state-decoded combinationally from state and the decoder inputs.

Test Plan:
- Reset asserted mid-MEM with mem_write_in=1 -> next cycle: state=0, prog_ctr=0, mem_write_en=0, all counters 0.
- start with 3 ALU instructions, reg_write_in=1, PROG_LEN=3 -> reg_write_en pulses at cycles 4, 8, 12; done=1 after the FETCH with prog_ctr=3; instr_cnt=3; cycle_cnt=13.
- Jump at PC 5 with target=0x020 -> the next FETCH sees prog_ctr=0x020; reg_write_en=0 during that WB.
- Conditional branch at PC 7, target=0x100: first with alu_cond=0 -> prog_ctr=8; then with alu_cond=1 -> prog_ctr=0x100.
- Store with mem_ready held low 3 cycles -> mem_write_en high for 1 cycle only; MEM lasts 4 cycles; mem_ready never rising -> WB after 15 cycles.
- start pulsed during EXEC -> ignored; start while done=1 -> prog_ctr=0, counters cleared, state=FETCH.
